poly_voice_mixer: RTL and testbench

//  Time-multiplexed N-voice mixer for the synth datapath. On each sample tick it sweeps the voice slots.
//  Per slot it sums two oscillator samples and scales them by the slot's envelope.
//  The results are accumulated and attenuated, then saturated into one signed audio sample with a valid strobe.

---
 rtl/poly_voice_mixer_if.sv | 31 +++
 rtl/poly_voice_mixer.sv | 138 +++++++++++++
 tb/tb_poly_voice_mixer.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/poly_voice_mixer_if.sv
// Voice-bank / audio-output bundle of the poly voice mixer.
interface poly_voice_mixer_if #(
   parameter int unsigned NUM_VOICES = 8,
   parameter int unsigned W          = 16
);
   localparam int unsigned SEL_W = $clog2(NUM_VOICES);

   logic                  sample_tick;
   logic [NUM_VOICES-1:0] voice_en;
   logic [SEL_W-1:0]      voice_sel;
   logic signed [W-1:0]   osc0;
   logic signed [W-1:0]   osc1;
   logic signed [W-1:0]   env;
   logic                  busy;
   logic signed [W-1:0]   out;
   logic                  out_valid;
   logic                  clip;
   logic                  missed_tick;

   // Voice banks and sample requester side.
   modport master (
      output sample_tick, voice_en, osc0, osc1, env,
      input  voice_sel, busy, out, out_valid, clip, missed_tick
   );

   // Mixer side.
   modport slave (
      input  sample_tick, voice_en, osc0, osc1, env,
      output voice_sel, busy, out, out_valid, clip, missed_tick
   );
endinterface

// File: rtl/poly_voice_mixer.sv
// Time-multiplexed N-voice mixer: sweeps the voice slots once per sample tick,
// accumulates (osc0+osc1)*env per enabled slot, attenuates and saturates.
module poly_voice_mixer #(
   parameter int unsigned NUM_VOICES = 8,
   parameter int unsigned W          = 16,
   parameter int unsigned OUT_SHIFT  = 3
) (
   input logic clk,
   input logic rst,
   poly_voice_mixer_if.slave bus
);
   localparam int unsigned IDX_W  = $clog2(NUM_VOICES);
   localparam int unsigned SUM_W  = W + 1;
   localparam int unsigned PROD_W = 2 * W + 1;
   localparam int unsigned TERM_W = W + 1;
   localparam int unsigned ACC_W  = W + 1 + IDX_W;

   localparam logic [IDX_W-1:0]        LAST_IDX = IDX_W'(NUM_VOICES - 1);
   localparam logic signed [ACC_W-1:0] SAT_MAX  = ACC_W'((64'sd1 <<< (W - 1)) - 64'sd1);
   localparam logic signed [ACC_W-1:0] SAT_MIN  = ACC_W'(-(64'sd1 <<< (W - 1)));

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ACCUM  = 2'd1;
   localparam logic [1:0] ST_FINISH = 2'd2;

   logic [1:0]               state, state_nxt;
   logic [IDX_W-1:0]         idx, idx_nxt;
   logic signed [ACC_W-1:0]  acc, acc_nxt;
   logic signed [W-1:0]      out_q, out_nxt;
   logic                     out_valid_q, out_valid_nxt;
   logic                     clip_q, clip_nxt;
   logic                     missed_q, missed_nxt;
   logic                     busy_q, busy_nxt;

   logic signed [SUM_W-1:0]  sum_c;
   logic signed [PROD_W-1:0] prod_c;
   logic signed [TERM_W-1:0] term_c;
   logic signed [ACC_W-1:0]  term_ext_c;
   logic signed [ACC_W-1:0]  shifted_c;

   // Per-slot term: floor(((osc0 + osc1) * env) / 2^W), plus the attenuated accumulator.
   always_comb begin
      sum_c      = SUM_W'(bus.osc0) + SUM_W'(bus.osc1);
      prod_c     = PROD_W'(bus.env) * PROD_W'(sum_c);
      term_c     = prod_c[PROD_W-1:W];
      term_ext_c = {{(ACC_W - TERM_W){term_c[TERM_W-1]}}, term_c};
      shifted_c  = acc >>> OUT_SHIFT;
   end

   // Next-state and next-output logic of the sweep controller.
   always_comb begin
      state_nxt     = state;
      idx_nxt       = idx;
      acc_nxt       = acc;
      out_nxt       = out_q;
      clip_nxt      = clip_q;
      out_valid_nxt = 1'b0;
      missed_nxt    = missed_q;

      // A request arriving mid-sweep is dropped but remembered.
      if (bus.sample_tick && (state != ST_IDLE)) begin
         missed_nxt = 1'b1;
      end

      case (state)
         ST_IDLE: begin
            if (bus.sample_tick) begin
               acc_nxt   = '0;
               idx_nxt   = '0;
               state_nxt = ST_ACCUM;
            end
         end
         ST_ACCUM: begin
            if (bus.voice_en[idx]) begin
               acc_nxt = acc + term_ext_c;
            end
            // idx returns to 0 here so voice_sel reads 0 outside the sweep.
            if (idx == LAST_IDX) begin
               idx_nxt   = '0;
               state_nxt = ST_FINISH;
            end else begin
               idx_nxt = idx + IDX_W'(1);
            end
         end
         ST_FINISH: begin
            out_valid_nxt = 1'b1;
            idx_nxt       = '0;
            state_nxt     = ST_IDLE;
            if (shifted_c > SAT_MAX) begin
               out_nxt  = SAT_MAX[W-1:0];
               clip_nxt = 1'b1;
            end else if (shifted_c < SAT_MIN) begin
               out_nxt  = SAT_MIN[W-1:0];
               clip_nxt = 1'b1;
            end else begin
               out_nxt  = shifted_c[W-1:0];
               clip_nxt = 1'b0;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
            idx_nxt   = '0;
         end
      endcase

      busy_nxt = (state_nxt != ST_IDLE);
   end

   // State and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= ST_IDLE;
         idx         <= '0;
         acc         <= '0;
         out_q       <= '0;
         out_valid_q <= 1'b0;
         clip_q      <= 1'b0;
         missed_q    <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state       <= state_nxt;
         idx         <= idx_nxt;
         acc         <= acc_nxt;
         out_q       <= out_nxt;
         out_valid_q <= out_valid_nxt;
         clip_q      <= clip_nxt;
         missed_q    <= missed_nxt;
         busy_q      <= busy_nxt;
      end
   end

   assign bus.voice_sel   = idx;
   assign bus.busy        = busy_q;
   assign bus.out         = out_q;
   assign bus.out_valid   = out_valid_q;
   assign bus.clip        = clip_q;
   assign bus.missed_tick = missed_q;
endmodule

// File: tb/tb_poly_voice_mixer.sv
// Scoreboard bench for poly_voice_mixer: two instances (OUT_SHIFT 3 and 0)
// share the same voice banks and requests; a behavioural model predicts each sample.
module tb_poly_voice_mixer;
   localparam int unsigned NV = 8;
   localparam int unsigned W  = 16;

   typedef struct {
      logic signed [W-1:0] out;
      logic                clip;
      int                  cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;
   int   n_chk = 0;
   int   n_pass = 0;
   int   sweep_end;
   bit   exp_missed;

   logic                  tick;
   logic [NV-1:0]         en;
   logic signed [W-1:0]   osc0_mem [NV];
   logic signed [W-1:0]   osc1_mem [NV];
   logic signed [W-1:0]   env_mem  [NV];

   exp_t q3[$];
   exp_t q0[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   poly_voice_mixer_if #(.NUM_VOICES(NV), .W(W)) ifc3 ();
   poly_voice_mixer_if #(.NUM_VOICES(NV), .W(W)) ifc0 ();

   poly_voice_mixer #(.NUM_VOICES(NV), .W(W), .OUT_SHIFT(3)) dut3 (
      .clk(clk), .rst(rst), .bus(ifc3.slave));
   poly_voice_mixer #(.NUM_VOICES(NV), .W(W), .OUT_SHIFT(0)) dut0 (
      .clk(clk), .rst(rst), .bus(ifc0.slave));

   // Voice banks: combinational lookup by the slot each mixer presents.
   assign ifc3.sample_tick = tick;
   assign ifc3.voice_en    = en;
   assign ifc3.osc0        = osc0_mem[ifc3.voice_sel];
   assign ifc3.osc1        = osc1_mem[ifc3.voice_sel];
   assign ifc3.env         = env_mem[ifc3.voice_sel];
   assign ifc0.sample_tick = tick;
   assign ifc0.voice_en    = en;
   assign ifc0.osc0        = osc0_mem[ifc0.voice_sel];
   assign ifc0.osc1        = osc1_mem[ifc0.voice_sel];
   assign ifc0.env         = env_mem[ifc0.voice_sel];

   task automatic check(input string name, input longint act, input longint exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   function automatic longint floor_div_pow2(input longint v, input int s);
      longint d = longint'(1) << s;
      longint q = v / d;
      if ((v < 0) && (q * d != v)) q = q - 1;
      return q;
   endfunction

   // Reference: mathematical sum of floor terms, floor attenuation, clamp to W bits.
   function automatic exp_t model(input int shift, input int tick_cyc);
      longint acc = 0;
      longint r;
      longint smax = (longint'(1) << (W - 1)) - 1;
      longint smin = -(longint'(1) << (W - 1));
      exp_t   e;
      for (int k = 0; k < NV; k++) begin
         if (en[k]) begin
            acc += floor_div_pow2((longint'(osc0_mem[k]) + longint'(osc1_mem[k])) * longint'(env_mem[k]), W);
         end
      end
      r = floor_div_pow2(acc, shift);
      if (r > smax) begin
         e.out = W'(smax); e.clip = 1'b1;
      end else if (r < smin) begin
         e.out = W'(smin); e.clip = 1'b1;
      end else begin
         e.out = W'(r); e.clip = 1'b0;
      end
      e.cyc = tick_cyc + NV + 1;
      return e;
   endfunction

   // Call just after a negedge: raises the request for the next rising edge.
   task automatic pulse_tick();
      int c = cyc + 1;
      if (c > sweep_end) begin
         q3.push_back(model(3, c));
         q0.push_back(model(0, c));
         sweep_end = c + NV + 1;
      end else begin
         exp_missed = 1'b1;
      end
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
   endtask

   // Returns on the negedge of the cycle the current sample is presented.
   task automatic wait_done();
      int budget = 40;
      while ((cyc < sweep_end) && (budget > 0)) begin
         @(negedge clk);
         budget--;
      end
      if (budget == 0) check("sweep_timeout", 0, 1);
   endtask

   task automatic fill(input logic signed [W-1:0] a, input logic signed [W-1:0] b,
                       input logic signed [W-1:0] g);
      for (int k = 0; k < NV; k++) begin
         osc0_mem[k] = a; osc1_mem[k] = b; env_mem[k] = g;
      end
   endtask

   function automatic logic signed [W-1:0] rnd_sample();
      case ($urandom_range(0, 3))
         0:       return 16'sh7FFF;
         1:       return 16'sh8000;
         default: return W'($urandom);
      endcase
   endfunction

   // Monitor, OUT_SHIFT=3 instance.
   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         if (ifc3.out_valid) begin
            if (q3.size() == 0) check("unexpected_valid_s3", 1, 0);
            else begin
               e = q3.pop_front();
               check("out_s3", $unsigned(ifc3.out), $unsigned(e.out));
               check("clip_s3", ifc3.clip, e.clip);
               check("latency_s3", cyc, e.cyc);
            end
         end else if ((q3.size() != 0) && (cyc > q3[0].cyc)) begin
            check("missing_valid_s3", 0, 1);
            e = q3.pop_front();
         end
      end
   end

   // Monitor, OUT_SHIFT=0 instance.
   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         if (ifc0.out_valid) begin
            if (q0.size() == 0) check("unexpected_valid_s0", 1, 0);
            else begin
               e = q0.pop_front();
               check("out_s0", $unsigned(ifc0.out), $unsigned(e.out));
               check("clip_s0", ifc0.clip, e.clip);
               check("latency_s0", cyc, e.cyc);
            end
         end else if ((q0.size() != 0) && (cyc > q0[0].cyc)) begin
            check("missing_valid_s0", 0, 1);
            e = q0.pop_front();
         end
      end
   end

   initial begin
      tick = 1'b0;
      en = '0;
      fill(16'sh0000, 16'sh0000, 16'sh0000);
      sweep_end = -100;
      exp_missed = 1'b0;
      rst = 1'b1;
      repeat (3) @(negedge clk);

      check("rst_busy", ifc3.busy, 0);
      check("rst_voice_sel", ifc3.voice_sel, 0);
      check("rst_out", $unsigned(ifc3.out), 0);
      check("rst_out_valid", ifc3.out_valid, 0);
      check("rst_clip", ifc3.clip, 0);
      check("rst_missed", ifc3.missed_tick, 0);
      rst = 1'b0;
      @(negedge clk);

      // All slots enabled, 0x4000 * 0x7FFF -> 0x1FFF per slot.
      fill(16'sh4000, 16'sh0000, 16'sh7FFF);
      en = 8'hFF;
      pulse_tick();
      check("busy_in_sweep", ifc3.busy, 1);
      wait_done();
      check("case1_out", $unsigned(ifc3.out), 16'h1FFF);
      check("case1_valid", ifc3.out_valid, 1);
      @(negedge clk);
      check("valid_one_cycle", ifc3.out_valid, 0);
      check("out_holds", $unsigned(ifc3.out), 16'h1FFF);

      en = 8'h01;
      pulse_tick();
      wait_done();
      check("case2_one_slot", $unsigned(ifc3.out), 16'h03FF);
      en = 8'h00;
      pulse_tick();
      wait_done();
      check("case2_none", $unsigned(ifc3.out), 16'h0000);
      check("case2_valid", ifc3.out_valid, 1);

      // Saturation on the unattenuated instance.
      en = 8'hFF;
      fill(16'sh7FFF, 16'sh7FFF, 16'sh7FFF);
      pulse_tick();
      wait_done();
      check("case3_pos_out", $unsigned(ifc0.out), 16'h7FFF);
      check("case3_pos_clip", ifc0.clip, 1);
      fill(16'sh8000, 16'sh8000, 16'sh7FFF);
      pulse_tick();
      wait_done();
      check("case3_neg_out", $unsigned(ifc0.out), 16'h8000);
      check("case3_neg_clip", ifc0.clip, 1);

      // Tick while busy is dropped and sticky-flagged; tick at e+10 accepted.
      fill(16'sh4000, 16'sh0000, 16'sh7FFF);
      check("missed_before", ifc3.missed_tick, 0);
      pulse_tick();
      repeat (2) @(negedge clk);
      pulse_tick();
      wait_done();
      @(negedge clk);
      check("case4_missed_s3", ifc3.missed_tick, 1);
      check("case4_missed_s0", ifc0.missed_tick, 1);
      pulse_tick();
      wait_done();
      check("case4_reaccept", $unsigned(ifc3.out), 16'h1FFF);

      // Reset mid-sweep at idx=4.
      pulse_tick();
      repeat (4) @(negedge clk);
      check("pre_reset_sel", ifc3.voice_sel, 4);
      rst = 1'b1;
      #1;
      check("case5_out", $unsigned(ifc3.out), 0);
      check("case5_busy", ifc3.busy, 0);
      check("case5_sel", ifc3.voice_sel, 0);
      check("case5_valid", ifc3.out_valid, 0);
      check("case5_missed", ifc3.missed_tick, 0);
      q3.delete();
      q0.delete();
      sweep_end = -100;
      exp_missed = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      repeat (12) @(negedge clk);
      pulse_tick();
      wait_done();
      check("case5_after", $unsigned(ifc3.out), 16'h1FFF);

      // Distinct per-slot oscillators, voice_sel stepping.
      for (int k = 0; k < NV; k++) begin
         osc0_mem[k] = W'(k * 16'h0800);
         osc1_mem[k] = 16'sh0000;
         env_mem[k]  = 16'sh7FFF;
      end
      pulse_tick();
      for (int k = 0; k < NV; k++) begin
         check("case6_voice_sel", ifc3.voice_sel, k);
         @(negedge clk);
      end
      check("case6_sel_finish", ifc3.voice_sel, 0);
      wait_done();

      // Randomised samples, occasional dropped ticks.
      for (int it = 0; it < 30; it++) begin
         for (int k = 0; k < NV; k++) begin
            osc0_mem[k] = rnd_sample();
            osc1_mem[k] = rnd_sample();
            env_mem[k]  = rnd_sample();
         end
         en = NV'($urandom);
         pulse_tick();
         if ($urandom_range(0, 2) == 0) begin
            repeat ($urandom_range(0, 8)) @(negedge clk);
            pulse_tick();
         end
         wait_done();
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end

      repeat (3) @(negedge clk);
      check("final_missed_s3", ifc3.missed_tick, exp_missed);
      check("final_missed_s0", ifc0.missed_tick, exp_missed);
      check("final_queue_s3", q3.size(), 0);
      check("final_queue_s0", q0.size(), 0);
      check("final_idle", ifc3.busy, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
